// File: rtl/tt_um_operand_sequencer.sv
// rtl/tt_um_operand_sequencer.sv - two-operand byte adder sequenced by a valid/ready handshake
// Optional accumulate mode: define SEQ_ACCUM_EN.
module tt_um_operand_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {WAIT_A, WAIT_B, SUM, HOLD} state_t;

  state_t     r_state;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic [7:0] r_sum;
  logic       r_carry;
  logic       r_ovf;

  logic       w_valid;
  logic       w_clear;
  logic       w_ack;
  logic       w_ready;
  logic       w_hs;
  logic       w_done;
  logic [8:0] w_add;
  logic       w_ovf;
  logic       w_unused;

  assign w_valid  = uio_in[0];
  assign w_clear  = uio_in[2];
  assign w_ack    = uio_in[6];
  assign w_unused = &{1'b0, uio_in[7], uio_in[5:3], uio_in[1]};

`ifdef SEQ_ACCUM_EN
  logic r_acc;
  assign w_ready = ena && (r_state != SUM);
`else
  assign w_ready = ena && ((r_state == WAIT_A) || (r_state == WAIT_B));
`endif

  assign w_hs   = w_valid && w_ready;
  assign w_done = (r_state == HOLD);
  assign w_add  = {1'b0, r_a} + {1'b0, r_b};
  assign w_ovf  = (r_a[7] == r_b[7]) && (w_add[7] != r_a[7]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= WAIT_A;
      r_a     <= 8'h00;
      r_b     <= 8'h00;
      r_sum   <= 8'h00;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
`ifdef SEQ_ACCUM_EN
      r_acc   <= 1'b0;
`endif
    end else if (w_clear) begin
      // Clear wins over handshake and ack, and works even with ena low.
      r_state <= WAIT_A;
      r_sum   <= 8'h00;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (ena) begin
      case (r_state)
        WAIT_A: begin
          if (w_hs) begin
            r_a     <= ui_in;
            r_state <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (w_hs) begin
            r_b     <= ui_in;
            r_state <= SUM;
`ifdef SEQ_ACCUM_EN
            r_acc   <= 1'b0;
`endif
          end
        end
        SUM: begin
          r_sum   <= w_add[7:0];
`ifdef SEQ_ACCUM_EN
          // Carry is sticky only across a chain of accumulations.
          r_carry <= w_add[8] | (r_acc & r_carry);
`else
          r_carry <= w_add[8];
`endif
          r_ovf   <= w_ovf;
          r_state <= HOLD;
        end
        HOLD: begin
          if (w_ack) begin
            r_state <= WAIT_A;
          end
`ifdef SEQ_ACCUM_EN
          else if (w_hs) begin
            r_a     <= r_sum;
            r_b     <= ui_in;
            r_acc   <= 1'b1;
            r_state <= SUM;
          end
`endif
        end
        default: r_state <= WAIT_A;
      endcase
    end
  end

  assign uo_out  = r_sum;
  assign uio_out = {2'b00, r_ovf, r_carry, w_done, 1'b0, w_ready, 1'b0};
  assign uio_oe  = 8'b0011_1010;

endmodule

// File: tb/tb_tt_um_operand_sequencer.sv
// tb/tb_tt_um_operand_sequencer.sv - scoreboard bench for tt_um_operand_sequencer
module tb_tt_um_operand_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  logic valid, clear, ack;
  assign uio_in = {1'b0, ack, 3'b000, clear, 1'b0, valid};

  wire ready = uio_out[1];
  wire done  = uio_out[3];
  wire carry = uio_out[4];
  wire ovf   = uio_out[5];

  tt_um_operand_sequencer dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct packed { logic [7:0] s; logic c; logic v; } exp_t;
  exp_t sb[$];

  // Reference model: phase 0 expects A, 1 expects B, 2 means a result is held.
  int         m_phase = 0;
  logic [7:0] m_a = 0;
  logic [7:0] m_res = 0;
  logic       m_carry = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    int sum, ss;
    byte sa, sb_;
    logic [7:0] opa;
    logic cin;
    exp_t e;
    @(negedge clk);
    ui_in = b;
    valid = 1'b1;
    if (m_phase < 2) check("ready_wait_state", ready, ena);
    while (!ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      check("send_timeout", 0, 1);
      valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 valid = 1'b0;
    if (m_phase == 0) begin
      m_a = b;
      m_phase = 1;
    end else begin
      opa = (m_phase == 1) ? m_a : m_res;
      cin = (m_phase == 1) ? 1'b0 : m_carry;
      sum = int'(opa) + int'(b);
      sa = opa;
      sb_ = b;
      ss = int'(sa) + int'(sb_);
      e.s = sum[7:0];
      e.c = (sum > 255) || cin;
      e.v = (ss > 127) || (ss < -128);
      sb.push_back(e);
      m_res = e.s;
      m_carry = e.c;
      m_phase = 2;
      check("done_low_in_sum", done, 0);
      @(posedge clk);
      #1 check("done_latency", done, 1);
    end
  endtask

  task automatic do_ack();
    @(negedge clk);
    ack = 1'b1;
    @(posedge clk);
    #1 ack = 1'b0;
    m_phase = 0;
    check("ack_done_low", done, 0);
    check("ack_ready", ready, 1);
    check("ack_sum_kept", uo_out, m_res);
  endtask

  task automatic do_clear(input logic ena_during);
    @(negedge clk);
    clear = 1'b1;
    ena = ena_during;
    @(posedge clk);
    #1 clear = 1'b0;
    ena = 1'b1;
    m_phase = 0;
    m_res = 0;
    m_carry = 0;
    check("clear_sum", uo_out, 0);
    check("clear_flags", {carry, ovf, done}, 0);
  endtask

  task automatic pair(input logic [7:0] a, input logic [7:0] b);
    send(a);
    send(b);
    do_ack();
  endtask

  // Monitor: pops an expectation each time a result is presented.
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_done = 1'b0;
    end else begin
      if (done && !prev_done) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          automatic exp_t e = sb.pop_front();
          check("sum", uo_out, e.s);
          check("carry", carry, e.c);
          check("overflow", ovf, e.v);
        end
      end
      check("uio_out_unused_zero", uio_out & 8'hC5, 0);
      prev_done = done;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00; valid = 1'b0; clear = 1'b0; ack = 1'b0;
    #23;
    check("reset_uo_out", uo_out, 0);
    check("reset_uio_out", uio_out, 8'h02);
    check("uio_oe", uio_oe, 8'h3A);
    @(negedge clk);
    rst_n = 1'b1;

    pair(8'h3C, 8'h05);
    pair(8'hFF, 8'h01);
    pair(8'h7F, 8'h01);
    pair(8'h80, 8'h80);

    // Clear after A discards it; second clear taken with ena low.
    send(8'h11);
    do_clear(1'b1);
    send(8'h22);
    do_clear(1'b0);
    send(8'h22);
    // ena low with valid high: nothing may be accepted.
    @(negedge clk);
    ena = 1'b0; valid = 1'b1; ui_in = 8'hEE;
    repeat (3) begin
      @(negedge clk);
      check("ena_low_ready", ready, 0);
    end
    valid = 1'b0; ena = 1'b1;
    send(8'h33);
    do_ack();

    // Reset while in SUM: outputs drop at once, operands discarded.
    send(8'h10);
    @(negedge clk);
    ui_in = 8'h20; valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_sum_uo_out", uo_out, 0);
    check("rst_sum_flags", {carry, ovf, done}, 0);
    sb.delete();
    m_phase = 0; m_res = 0; m_carry = 0;
    @(negedge clk);
    rst_n = 1'b1;
    pair(8'h01, 8'h02);

    // Valid offered while a result is held.
    send(8'h10);
    send(8'h20);
`ifdef SEQ_ACCUM_EN
    send(8'h30);
    send(8'hB0);
    send(8'h01);
    check("accum_sticky_carry", carry, 1);
    @(negedge clk);
    ack = 1'b1; valid = 1'b1; ui_in = 8'h77;
    @(posedge clk);
    #1 ack = 1'b0; valid = 1'b0;
    m_phase = 0;
    check("ack_beats_valid_done", done, 0);
    check("ack_beats_valid_sum", uo_out, m_res);
`else
    @(negedge clk);
    valid = 1'b1; ui_in = 8'h55;
    repeat (3) begin
      @(negedge clk);
      check("hold_ready_low", ready, 0);
    end
    valid = 1'b0;
    check("hold_sum_stable", uo_out, 8'h30);
    check("hold_done", done, 1);
    do_ack();
`endif

    for (int i = 0; i < 30; i++) begin
      logic [7:0] a, b;
      a = 8'($urandom);
      b = 8'($urandom);
      if (i % 7 == 0) a = 8'h80 | a;
      if (i % 7 == 0) b = 8'h80 | b;
      send(a);
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk);
        ena = 1'b0; valid = 1'b1; ui_in = 8'($urandom);
        repeat ($urandom_range(1, 3)) begin
          @(negedge clk);
          check("rand_ena_low_ready", ready, 0);
        end
        valid = 1'b0; ena = 1'b1;
      end
      send(b);
      do_ack();
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
